// File: rtl/sysid_pkg.sv
`default_nettype none
// ============================================================================
// Package : sysid_pkg
// Brief   : Shared types and constants for the system-ID boot checker.
// Rev     : 1.0 - initial release
// ============================================================================
package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Single source for the software header generator and the RTL defaults.
    localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1456093976;

    function automatic logic sysid_is_read(input sysid_state_e s);
        return (s == ST_RD_ID) || (s == ST_RD_TS);
    endfunction

endpackage : sysid_pkg
`default_nettype wire

// File: rtl/sysid_rd_timer.sv
`default_nettype none
// ============================================================================
// Module : sysid_rd_timer
// Brief  : Loadable down-counter with terminal-count flag for read timeouts.
// Rev    : 1.0 - initial release
// ============================================================================
module sysid_rd_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule : sysid_rd_timer
`default_nettype wire

// File: rtl/sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// Module : sysid_boot_checker
// Brief  : Reads sysid words 0/1 over Avalon-MM and flags image mismatches.
// Rev    : 1.0 - initial release
// ============================================================================
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [7:0] C_TMO_LOAD  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] C_MAX_RETRY = 3'(MAX_RETRIES);

    sysid_state_e state_q, state_d;
    logic         first_q;
    logic         abort_q, abort_d;
    logic [2:0]   retry_q, retry_d;
    logic [31:0]  id_value_q, id_value_d;
    logic [31:0]  ts_value_q, ts_value_d;
    logic         id_ok_q, id_ok_d;
    logic         ts_ok_q, ts_ok_d;
    logic         timeout_q, timeout_d;

    logic         w_in_read;
    logic         w_active;
    logic         w_accept;
    logic         w_expire;
    logic         w_tc;
    logic         w_timer_load;

    assign w_in_read = sysid_is_read(state_q);
    // The abort cycle keeps the read state but deasserts the strobe.
    assign w_active  = w_in_read && !abort_q;
    assign w_accept  = w_active && !avm_waitrequest;
    assign w_expire  = w_active && avm_waitrequest && w_tc;

    sysid_rd_timer #(
        .WIDTH (8)
    ) u_rd_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (w_timer_load),
        .load_val_i (C_TMO_LOAD),
        .dec_i      (w_active && avm_waitrequest),
        .tc_o       (w_tc)
    );

    always_comb begin
        state_d      = state_q;
        abort_d      = 1'b0;
        retry_d      = retry_q;
        id_value_d   = id_value_q;
        ts_value_d   = ts_value_q;
        id_ok_d      = id_ok_q;
        ts_ok_d      = ts_ok_q;
        timeout_d    = timeout_q;
        w_timer_load = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start || (state_q == ST_IDLE && AUTO_START && first_q)) begin
                    state_d      = ST_RD_ID;
                    id_ok_d      = 1'b0;
                    ts_ok_d      = 1'b0;
                    timeout_d    = 1'b0;
                    retry_d      = '0;
                    w_timer_load = 1'b1;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                if (abort_q) begin
                    if (retry_q < C_MAX_RETRY) begin
                        retry_d      = retry_q + 3'd1;
                        state_d      = ST_RD_ID;
                        w_timer_load = 1'b1;
                    end else begin
                        timeout_d = 1'b1;
                        id_ok_d   = 1'b0;
                        ts_ok_d   = 1'b0;
                        state_d   = ST_DONE;
                    end
                end else if (w_accept) begin
                    if (state_q == ST_RD_ID) begin
                        id_value_d   = avm_readdata;
                        state_d      = ST_RD_TS;
                        w_timer_load = 1'b1;
                    end else begin
                        ts_value_d = avm_readdata;
                        state_d    = ST_CHECK;
                    end
                end else if (w_expire) begin
                    abort_d = 1'b1;
                end
            end
            ST_CHECK: begin
                id_ok_d = (id_value_q == EXPECTED_ID);
                ts_ok_d = (ts_value_q == EXPECTED_TS);
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b1;
            abort_q    <= 1'b0;
            retry_q    <= '0;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= 1'b0;
            abort_q    <= abort_d;
            retry_q    <= retry_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
        end
    end

    assign avm_read    = w_active;
    assign avm_address = (state_q == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy        = w_in_read || (state_q == ST_CHECK);
    assign done        = (state_q == ST_DONE);
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule : sysid_boot_checker
`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_sysid_boot_checker
// Brief  : Randomized self-checking bench with a sequence-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1456093976;
    localparam int          TMO    = 4;
    localparam int          MAXR   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    int          n_chk = 0;
    int          n_err = 0;
    int          plan[6];
    int          pidx = 0;
    logic [31:0] id_data = EXP_ID;
    logic [31:0] ts_data = EXP_TS;
    logic [31:0] exp_id = '0;
    logic [31:0] exp_ts = '0;

    sysid_boot_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (MAXR),
        .AUTO_START     (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Sequence outcome from the stall plan: a read stalling TMO or more cycles
    // costs TMO strobe cycles plus one dead cycle and restarts the whole sequence.
    function automatic void ref_sequence(input int st[6], output int lat,
                                         output bit tmo, output bit gid, output bit gts);
        int  k;
        bit  ab;
        k = 0; lat = 1; tmo = 0; gid = 0; gts = 0;
        for (int a = 0; a <= MAXR; a++) begin
            ab = 0;
            if (st[k] >= TMO) begin
                lat += TMO + 1; k++; ab = 1;
            end else begin
                lat += st[k] + 1; k++; gid = 1;
                if (st[k] >= TMO) begin
                    lat += TMO + 1; k++; ab = 1;
                end else begin
                    lat += st[k] + 1; k++; gts = 1;
                end
            end
            if (!ab) begin
                lat += 1;
                return;
            end
            if (a == MAXR) begin
                tmo = 1;
                return;
            end
        end
    endfunction

    // Slave: each new read transaction takes the next stall count from the plan.
    initial begin
        bit   s_act, s_rst;
        logic s_addr;
        int   s_len, s_stall, s_exp;
        s_act = 0; s_rst = 0; s_addr = 0; s_len = 0; s_stall = 0;
        forever begin
            @(posedge clock);
            #2;
            if (s_act && (!avm_read || avm_address != s_addr)) begin
                s_exp = (s_stall + 1 < TMO) ? s_stall + 1 : TMO;
                if (!s_rst) check("rd_len", 32'(s_len), 32'(s_exp));
                s_act = 0;
            end
            if (avm_read && !s_act) begin
                s_act   = 1;
                s_rst   = 0;
                s_addr  = avm_address;
                s_stall = (pidx < 6) ? plan[pidx] : 0;
                pidx++;
                s_len   = 0;
            end
            if (s_act) begin
                if (reset) s_rst = 1;
                s_len++;
                avm_waitrequest = (s_len <= s_stall);
                avm_readdata    = avm_waitrequest ? $urandom : (avm_address ? ts_data : id_data);
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
                avm_readdata    = $urandom;
            end
        end
    end

    task automatic run_seq(input bit via_reset);
        int lat, n;
        bit tmo, gid, gts, seen;
        ref_sequence(plan, lat, tmo, gid, gts);
        if (via_reset) begin
            reset = 1'b1;
            @(posedge clock);
            #1;
            check("rst_ctl", 32'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 32'd0);
            check("rst_idv", id_value, 32'd0);
            check("rst_tsv", ts_value, 32'd0);
            exp_id = '0;
            exp_ts = '0;
        end
        pidx = 0;
        if (via_reset) reset = 1'b0;
        else start = 1'b1;
        n = 0;
        seen = 0;
        while (n < 150 && !seen) begin
            @(posedge clock);
            #1;
            n++;
            start = 1'b0;
            if (n == 1) check("clr", 32'({busy, done, id_ok, ts_ok, timeout}), 32'b10000);
            if (done) seen = 1;
            else if (busy && $urandom_range(0, 3) == 0) start = 1'b1;
        end
        check("latency", 32'(n), 32'(lat));
        if (gid) exp_id = id_data;
        if (gts) exp_ts = ts_data;
        check("timeout", 32'(timeout), 32'(tmo));
        check("id_ok", 32'(id_ok), 32'(!tmo && id_data == EXP_ID));
        check("ts_ok", 32'(ts_ok), 32'(!tmo && ts_data == EXP_TS));
        check("id_value", id_value, exp_id);
        check("ts_value", ts_value, exp_ts);
        repeat (2) begin
            @(posedge clock);
            #1;
            check("hold", 32'({done, busy, avm_read}), 32'b100);
        end
    endtask

    task automatic set_plan(input int a, input int b, input int c,
                            input int d, input int e, input int f);
        plan[0] = a; plan[1] = b; plan[2] = c;
        plan[3] = d; plan[4] = e; plan[5] = f;
    endtask

    initial begin
        int  n;
        bit  hit;
        // Zero-wait boot with AUTO_START.
        set_plan(0, 0, 0, 0, 0, 0);
        run_seq(1);
        // Timestamp off by one.
        ts_data = EXP_TS + 32'd1;
        run_seq(0);
        // Three stall cycles per read: accepted on the terminal-count cycle.
        ts_data = EXP_TS;
        set_plan(3, 3, 0, 0, 0, 0);
        run_seq(0);
        // One stall too many on the first ID read, then a clean retry.
        set_plan(TMO, 0, 0, 0, 0, 0);
        run_seq(0);
        // Stuck slave: every attempt aborts, final timeout.
        set_plan(9, 9, 9, 9, 9, 9);
        run_seq(0);
        // Reset while the timestamp read is stalled.
        set_plan(0, 3, 0, 0, 0, 0);
        pidx = 0;
        start = 1'b1;
        n = 0;
        hit = 0;
        while (n < 20 && !hit) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            n++;
            if (avm_read && avm_address) hit = 1;
        end
        check("reach_ts", 32'(hit), 32'd1);
        set_plan(0, 0, 0, 0, 0, 0);
        run_seq(1);
        // Randomized sequences.
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 6; j++) begin
                int r;
                r = $urandom_range(0, 9);
                plan[j] = (r < 5) ? 0 : (r < 8) ? int'($urandom_range(1, TMO - 1))
                                                : int'($urandom_range(TMO, TMO + 2));
            end
            case ($urandom_range(0, 3))
                0:       id_data = $urandom;
                default: id_data = EXP_ID;
            endcase
            case ($urandom_range(0, 4))
                0:       ts_data = $urandom;
                1:       ts_data = EXP_TS + 32'd1;
                2:       ts_data = EXP_TS - 32'd1;
                default: ts_data = EXP_TS;
            endcase
            run_seq($urandom_range(0, 5) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_sysid_boot_checker
`default_nettype wire
